ram_stream_port: RTL and testbench

Byte-stream initiator for the single-port data/instruction RAM: a command port selects write (load) or read (dump) of a byte range, and the block moves bytes between a valid/ready byte stream and the RAM word port (en/addr/wdata/we/be, read data one cycle after address). It sits between the debug/boot loader byte link and a RAM instance, replacing testbench backdoor loading in hardware.

---
 rtl/ram_stream_port_pkg.sv | 25 ++
 rtl/ram_stream_port_if.sv | 32 +++
 rtl/ram_stream_port.sv | 157 +++++++++++++++
 tb/tb_ram_stream_port.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_port_pkg.sv
// Shared types and constants for the RAM byte-stream port: FSM state
// encoding, byte-lane constants and the width used for the range check.
package ram_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_COLLECT = 3'd1,
        ST_WR_FLUSH   = 3'd2,
        ST_RD_REQ     = 3'd3,
        ST_RD_WAIT    = 3'd4,
        ST_RD_EMIT    = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERR        = 3'd7
    } state_e;

    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'd3;

    // End-of-range sum (byte address + length) needs the byte-address width
    // (word width + 2) plus the length width plus one carry bit, with margin.
    function automatic int rc_width(input int addr_width, input int len_width);
        return addr_width + len_width + 3;
    endfunction

endpackage

// File: rtl/ram_stream_port_if.sv
// Command port plus the two byte streams (write-in, read-out) of the RAM
// stream port. "master" is the loader/link side, "slave" is the port itself.
interface ram_stream_port_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH+1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;

    logic [7:0]            m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output s_data, s_valid, m_ready,
        input  cmd_ready, s_ready, m_data, m_valid
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  s_data, s_valid, m_ready,
        output cmd_ready, s_ready, m_data, m_valid
    );
endinterface

// File: rtl/ram_stream_port.sv
// Byte-stream initiator for a single-port 32-bit RAM. A command selects a
// load (stream -> RAM) or dump (RAM -> stream) of a byte range; bytes are
// packed into / unpacked from words using per-lane byte enables so that
// unaligned start and end bytes leave neighbouring RAM bytes untouched.
// Every output is decoded from registered state only.
module ram_stream_port
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WORDS  = 256,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_stream_port_if.slave      bus,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int RC_W = rc_width(ADDR_WIDTH, LEN_WIDTH);
    localparam logic [RC_W-1:0] BYTE_LIMIT = RC_W'(4 * NUM_WORDS);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [1:0]              lane_q,  lane_d;
    logic [LEN_WIDTH-1:0]    rem_q,   rem_d;
    logic [3:0][7:0]         buf_q,   buf_d;
    logic [3:0]              be_q,    be_d;

    logic [RC_W-1:0]         end_byte;
    logic                    range_err;

    // Widened so addr + len cannot overflow before comparing to the RAM size.
    assign end_byte  = RC_W'(bus.cmd_addr) + RC_W'(bus.cmd_len);
    assign range_err = (end_byte > BYTE_LIMIT);

    // State and datapath registers; reset abandons any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            lane_q  <= LANE_FIRST;
            rem_q   <= '0;
            buf_q   <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            be_q    <= be_d;
        end
    end

    // Next-state logic: command acceptance, byte packing and unpacking.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        be_d    = be_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    waddr_d = bus.cmd_addr[ADDR_WIDTH+1:2];
                    lane_d  = bus.cmd_addr[1:0];
                    rem_d   = bus.cmd_len;
                    be_d    = '0;
                    if (range_err) begin
                        state_d = ST_ERR;
                    end else if (bus.cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.cmd_write) begin
                        state_d = ST_WR_COLLECT;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end

            ST_WR_COLLECT: begin
                if (bus.s_valid) begin
                    buf_d[lane_q] = bus.s_data;
                    be_d[lane_q]  = 1'b1;
                    rem_d         = rem_q - LEN_ONE;
                    lane_d        = lane_q + 2'd1;
                    if (lane_q == LANE_LAST || rem_q == LEN_ONE) begin
                        state_d = ST_WR_FLUSH;
                    end
                end
            end

            ST_WR_FLUSH: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    be_d    = '0;
                    lane_d  = LANE_FIRST;
                    waddr_d = waddr_q + 1'b1;
                    state_d = ST_WR_COLLECT;
                end
            end

            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                buf_d   = ram_rdata_i;
                state_d = ST_RD_EMIT;
            end

            ST_RD_EMIT: begin
                if (bus.m_ready) begin
                    rem_d  = rem_q - LEN_ONE;
                    lane_d = lane_q + 2'd1;
                    if (rem_q == LEN_ONE) begin
                        state_d = ST_DONE;
                    end else if (lane_q == LANE_LAST) begin
                        waddr_d = waddr_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.s_ready   = (state_q == ST_WR_COLLECT);
    assign bus.m_valid   = (state_q == ST_RD_EMIT);
    assign bus.m_data    = buf_q[lane_q];

    assign ram_en_o    = (state_q == ST_WR_FLUSH) || (state_q == ST_RD_REQ);
    assign ram_we_o    = (state_q == ST_WR_FLUSH);
    assign ram_addr_o  = waddr_q;
    assign ram_wdata_o = (state_q == ST_WR_FLUSH) ? buf_q : '0;
    assign ram_be_o    = (state_q == ST_WR_FLUSH) ? be_q : 4'h0;

    assign done_o = (state_q == ST_DONE);
    assign err_o  = (state_q == ST_ERR);

endmodule

// File: tb/tb_ram_stream_port.sv
// Directed bench for ram_stream_port with a behavioural single-port RAM.
module tb_ram_stream_port;

    logic        clk;
    logic        rst_n;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        done_o, err_o;

    logic [31:0] mem [0:255];
    logic        bk_we;
    logic [7:0]  bk_addr;
    logic [31:0] bk_data;
    int          en_cnt, wr_cnt;

    int checks;
    int failures;

    ram_stream_port_if #(.ADDR_WIDTH(8), .LEN_WIDTH(16)) bus ();

    ram_stream_port #(.ADDR_WIDTH(8), .NUM_WORDS(256), .LEN_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_be_o    (ram_be),
        .ram_rdata_i (ram_rdata),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: byte-enabled write, one-cycle read latency, backdoor preload.
    always @(posedge clk) begin
        if (bk_we) begin
            mem[bk_addr] <= bk_data;
        end else if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                wr_cnt <= wr_cnt + 1;
                for (int i = 0; i < 4; i++)
                    if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        tick();
        bk_we = 1'b0;
    endtask

    task automatic send_cmd(input logic w, input logic [9:0] a, input logic [15:0] len);
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_len = len;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.s_valid = 1'b1; bus.s_data = b;
        while (!bus.s_ready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("s_ready_timeout", {31'd0, bus.s_ready}, 32'd1);
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic pull_byte(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        bus.m_ready = 1'b1;
        while (!bus.m_valid && n < 20) begin tick(); n++; end
        chk(tag, {24'd0, bus.m_data}, {24'd0, exp});
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 20) begin tick(); n++; end
        chk(tag, {31'd0, done_o}, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, wr0;
        checks = 0; failures = 0;
        en_cnt = 0; wr_cnt = 0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Aligned 4-byte write, cycle by cycle
        wr0 = wr_cnt;
        send_cmd(1'b1, 10'h000, 16'd4);
        chk("w1_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("w1_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data = 8'h11; tick();
        bus.s_data = 8'h22; tick();
        bus.s_data = 8'h33; tick();
        bus.s_data = 8'h44; tick();
        bus.s_valid = 1'b0;
        chk("w1_flush_en_we", {30'd0, ram_en, ram_we}, 32'd3);
        chk("w1_flush_addr", {24'd0, ram_addr}, 32'd0);
        chk("w1_flush_wdata", ram_wdata, 32'h44332211);
        chk("w1_flush_be", {28'd0, ram_be}, 32'hF);
        tick();
        chk("w1_done", {31'd0, done_o}, 32'd1);
        chk("w1_done_en", {31'd0, ram_en}, 32'd0);
        tick();
        chk("w1_done_pulse", {31'd0, done_o}, 32'd0);
        chk("w1_idle", {31'd0, bus.cmd_ready}, 32'd1);
        chk("w1_mem0", mem[0], 32'h44332211);
        chk("w1_writes", wr_cnt - wr0, 32'd1);

        // Unaligned write starting at lane 3, with stalls on s_valid
        preload(8'd0, 32'h01020304);
        preload(8'd1, 32'h05060708);
        wr0 = wr_cnt;
        send_cmd(1'b1, 10'h003, 16'd3);
        push_byte(8'hAA);
        tick(); tick();
        push_byte(8'hBB);
        tick();
        push_byte(8'hCC);
        wait_done("w2_done");
        chk("w2_mem0", mem[0], 32'hAA020304);
        chk("w2_mem1", mem[1], 32'h0506CCBB);
        chk("w2_writes", wr_cnt - wr0, 32'd2);

        // Unaligned read across a word boundary
        preload(8'd1, 32'hDDCCBBAA);
        preload(8'd2, 32'h44332211);
        en0 = en_cnt;
        send_cmd(1'b0, 10'h006, 16'd4);
        chk("r1_req_en_we", {30'd0, ram_en, ram_we}, 32'd2);
        chk("r1_req_be", {28'd0, ram_be}, 32'd0);
        chk("r1_req_addr", {24'd0, ram_addr}, 32'd1);
        chk("r1_req_m_valid", {31'd0, bus.m_valid}, 32'd0);
        tick();
        chk("r1_wait_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("r1_wait_addr", {24'd0, ram_addr}, 32'd1);
        tick();
        chk("r1_first_m_valid", {31'd0, bus.m_valid}, 32'd1);
        pull_byte("r1_b0", 8'hCC);
        pull_byte("r1_b1", 8'hDD);
        pull_byte("r1_b2", 8'h11);
        pull_byte("r1_b3", 8'h22);
        wait_done("r1_done");
        chk("r1_reads", en_cnt - en0, 32'd2);

        // Read with m_ready pattern 1-0-0-1
        send_cmd(1'b0, 10'h008, 16'd4);
        begin
            int n;
            n = 0;
            while (!bus.m_valid && n < 20) begin tick(); n++; end
        end
        chk("r2_b0", {24'd0, bus.m_data}, 32'h11);
        bus.m_ready = 1'b1; tick();
        chk("r2_b1", {24'd0, bus.m_data}, 32'h22);
        bus.m_ready = 1'b0; tick();
        chk("r2_stall1", {23'd0, bus.m_valid, bus.m_data}, 32'h122);
        tick();
        chk("r2_stall2", {23'd0, bus.m_valid, bus.m_data}, 32'h122);
        bus.m_ready = 1'b1; tick();
        chk("r2_b2", {24'd0, bus.m_data}, 32'h33);
        tick();
        chk("r2_b3", {24'd0, bus.m_data}, 32'h44);
        tick();
        bus.m_ready = 1'b0;
        chk("r2_done", {30'd0, done_o, bus.m_valid}, 32'd2);
        tick();

        // Out-of-range command and zero-length command
        en0 = en_cnt;
        send_cmd(1'b1, 10'h3FE, 16'd3);
        chk("e_err_pulse", {30'd0, err_o, done_o}, 32'd2);
        tick();
        chk("e_err_clear", {30'd0, err_o, bus.cmd_ready}, 32'd1);
        send_cmd(1'b0, 10'h010, 16'd0);
        chk("z_done_pulse", {30'd0, done_o, err_o}, 32'd2);
        tick();
        chk("ez_no_ram", en_cnt - en0, 32'd0);

        // Last legal word
        send_cmd(1'b1, 10'h3FC, 16'd4);
        chk("top_accepted", {31'd0, err_o}, 32'd0);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        wait_done("top_done");
        chk("top_mem255", mem[255], 32'h04030201);

        // Reset in the middle of collecting a word
        preload(8'd8, 32'hFFFFFFFF);
        wr0 = wr_cnt;
        send_cmd(1'b1, 10'h020, 16'd4);
        push_byte(8'h12);
        push_byte(8'h34);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_mid_en_sready", {30'd0, ram_en, bus.s_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_no_write", wr_cnt - wr0, 32'd0);
        chk("rst_mid_mem8", mem[8], 32'hFFFFFFFF);
        send_cmd(1'b1, 10'h020, 16'd1);
        push_byte(8'h5A);
        wait_done("post_rst_done");
        chk("post_rst_mem8", mem[8], 32'hFFFFFF5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
